statetrace_decoder: RTL



---
 rtl/statetrace_decoder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/statetrace_decoder.sv
// Decoder for the 2-bit up/down state trace: recovers direction, tracks position, counts illegal steps.
// Define STATETRACE_SYNC_EN to pass q_in/q_valid through a 2-flop synchroniser first (3-cycle latency).
module statetrace_decoder #(
  parameter int POS_W  = 8,
  parameter int ERRC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        q_in,
  input  logic              q_valid,
  input  logic              clr,
  output logic              dir,
  output logic              dir_valid,
  output logic              y,
  output logic              err,
  output logic [ERRC_W-1:0] err_cnt,
  output logic [POS_W-1:0]  pos
);

  typedef enum logic {WAIT_FIRST, TRACK} state_t;

  localparam logic [ERRC_W-1:0] ERRC_MAX = '1;

  logic [1:0] s_q;
  logic       s_valid;

`ifdef STATETRACE_SYNC_EN
  logic [2:0] sync_reg [0:1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= '0;
          else        sync_reg[gi] <= {q_valid, q_in};
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= '0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign s_valid = sync_reg[1][2];
  assign s_q     = sync_reg[1][1:0];
`else
  assign s_valid = q_valid;
  assign s_q     = q_in;
`endif

  state_t            state_reg;
  logic [1:0]        prev_reg;
  logic              dir_reg;
  logic              dir_valid_reg;
  logic              y_reg;
  logic              err_reg;
  logic [ERRC_W-1:0] err_cnt_reg;
  logic [POS_W-1:0]  pos_reg;
  logic [1:0]        delta;

  // Mod-4 difference falls out of the 2-bit wraparound subtraction.
  assign delta = s_q - prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= WAIT_FIRST;
      prev_reg      <= '0;
      dir_reg       <= 1'b0;
      dir_valid_reg <= 1'b0;
      y_reg         <= 1'b0;
      err_reg       <= 1'b0;
      err_cnt_reg   <= '0;
      pos_reg       <= '0;
    end else begin
      dir_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      if (clr) begin
        state_reg   <= WAIT_FIRST;
        prev_reg    <= '0;
        dir_reg     <= 1'b0;
        y_reg       <= 1'b0;
        err_cnt_reg <= '0;
        pos_reg     <= '0;
      end else if (s_valid) begin
        prev_reg <= s_q;
        y_reg    <= (s_q == 2'b11);
        case (state_reg)
          WAIT_FIRST: state_reg <= TRACK;
          TRACK: begin
            case (delta)
              2'd1: begin
                dir_reg       <= 1'b0;
                dir_valid_reg <= 1'b1;
                pos_reg       <= pos_reg + 1'b1;
              end
              2'd3: begin
                dir_reg       <= 1'b1;
                dir_valid_reg <= 1'b1;
                pos_reg       <= pos_reg - 1'b1;
              end
              default: begin
                // Q0 failed to toggle: flag it and resync on this sample.
                err_reg <= 1'b1;
                if (err_cnt_reg != ERRC_MAX) err_cnt_reg <= err_cnt_reg + 1'b1;
              end
            endcase
          end
          default: state_reg <= WAIT_FIRST;
        endcase
      end
    end
  end

  assign dir       = dir_reg;
  assign dir_valid = dir_valid_reg;
  assign y         = y_reg;
  assign err       = err_reg;
  assign err_cnt   = err_cnt_reg;
  assign pos       = pos_reg;

endmodule
